// File: rtl/paint_pkg.sv
// paint_pkg: shared types and constants for the SPI draw decoder.
//   color_t / coord_t   : colour code and pixel coordinate types
//   H_ACTIVE_DEF/V_ACTIVE_DEF : default visible raster size
//   ECHO_SYNC           : byte presented on sdo at the start of a frame
//   B0_*/B1_*           : bit positions of the packet fields
//   state_t             : decoder FSM states
// Build option: SPI_DRAW_CHECKSUM_EN adds the B3 checksum state.
package paint_pkg;

    typedef logic [2:0] color_t;
    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [7:0] ECHO_SYNC = 8'hA5;

    // B0 = {brush, color[2:0], x[9:6]}
    localparam int B0_BRUSH_BIT = 7;
    localparam int B0_COLOR_MSB = 6;
    localparam int B0_COLOR_LSB = 4;
    localparam int B0_XHI_MSB   = 3;
    localparam int B0_XHI_LSB   = 0;
    // B1 = {x[5:0], y[9:8]}; B2 = y[7:0]
    localparam int B1_XLO_MSB   = 7;
    localparam int B1_XLO_LSB   = 2;
    localparam int B1_YHI_MSB   = 1;
    localparam int B1_YHI_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
`ifdef SPI_DRAW_CHECKSUM_EN
        ST_B3,
`endif
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/spi_draw_decoder_if.sv
// spi_draw_decoder_if: SPI pins plus the pixel-store write port.
//   sck, sdi, cs_n : SPI inputs from the MCU (asynchronous)
//   sdo            : SPI echo output
//   x, y, new_color, brush, ready : committed draw command and strobe
//   err_cnt        : saturating dropped-packet count
// Modports: slave = decoder side, master = MCU/consumer side.
interface spi_draw_decoder_if;
    import paint_pkg::*;

    logic       sck;
    logic       sdi;
    logic       cs_n;
    logic       sdo;
    coord_t     x;
    coord_t     y;
    color_t     new_color;
    logic       brush;
    logic       ready;
    logic [7:0] err_cnt;

    modport slave (
        input  sck, sdi, cs_n,
        output sdo, x, y, new_color, brush, ready, err_cnt
    );

    modport master (
        output sck, sdi, cs_n,
        input  sdo, x, y, new_color, brush, ready, err_cnt
    );

endinterface

// File: rtl/spi_sync.sv
// spi_sync: brings sck/sdi/cs_n into the clk domain and edge-detects them.
//   clk                  : pixel clock
//   sck, sdi, cs_n       : asynchronous SPI pins
//   sdi_s, cs_n_s        : synchronised levels
//   sck_rise, sck_fall   : one-cycle pulses on synchronised sck edges
//   cs_n_rise, cs_n_fall : one-cycle pulses on synchronised cs_n edges
// SYNC_STAGES must be at least 2.
// The chains carry no reset on purpose: a reset while cs_n is held low
// must not look like a fresh cs_n fall once reset is released.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic sck,
    input  logic sdi,
    input  logic cs_n,
    output logic sck_rise,
    output logic sck_fall,
    output logic sdi_s,
    output logic cs_n_s,
    output logic cs_n_rise,
    output logic cs_n_fall
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;

    always_ff @(posedge clk) begin
        sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
        sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
        cs_q  <= {cs_q[SYNC_STAGES-2:0], cs_n};
        sck_d <= sck_s;
        cs_d  <= cs_n_s;
    end

    assign sck_s     = sck_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_q[SYNC_STAGES-1];
    assign sck_rise  =  sck_s & ~sck_d;
    assign sck_fall  = ~sck_s &  sck_d;
    assign cs_n_rise =  cs_n_s & ~cs_d;
    assign cs_n_fall = ~cs_n_s &  cs_d;

endmodule

// File: rtl/spi_draw_decoder.sv
// spi_draw_decoder: SPI-slave draw-packet receiver for the paint pipeline.
//   clk   : pixel clock, sole clock
//   reset : synchronous, active-high
//   bus   : spi_draw_decoder_if.slave (SPI pins, committed x/y/new_color/
//           brush with one-cycle ready strobe, err_cnt)
// Build option: SPI_DRAW_CHECKSUM_EN makes packets 4 bytes with
// B3 = B0^B1^B2; a mismatching packet is dropped and counted.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for cs_n to fall
// ST_B0     | receiving {brush, color, x[9:6]}
// ST_B1     | receiving {x[5:0], y[9:8]}
// ST_B2     | receiving y[7:0]
// ST_B3     | receiving checksum byte (SPI_DRAW_CHECKSUM_EN only)
// ST_COMMIT | one cycle after the last byte; ready is high here if valid
module spi_draw_decoder
    import paint_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_draw_decoder_if.slave     bus
);

    localparam coord_t H_LIM = coord_t'(H_ACTIVE);
    localparam coord_t V_LIM = coord_t'(V_ACTIVE);
`ifdef SPI_DRAW_CHECKSUM_EN
    localparam state_t LAST_BYTE = ST_B3;
`else
    localparam state_t LAST_BYTE = ST_B2;
`endif

    logic sck_rise, sck_fall, sdi_s, cs_n_s, cs_n_rise, cs_n_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .sck       (bus.sck),
        .sdi       (bus.sdi),
        .cs_n      (bus.cs_n),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .sdi_s     (sdi_s),
        .cs_n_s    (cs_n_s),
        .cs_n_rise (cs_n_rise),
        .cs_n_fall (cs_n_fall)
    );

    state_t     state, state_nx;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift;
    logic [7:0] b0_q, b1_q;
`ifdef SPI_DRAW_CHECKSUM_EN
    logic [7:0] b2_q;
`endif
    logic       skip_fall;
    coord_t     x_q, y_q;
    color_t     color_q;
    logic       brush_q, ready_q;
    logic [7:0] err_q;

    // decode strobes
    logic       in_pkt, start, abort, shift_en, byte_done, pkt_done;
    logic       pkt_ok, err_inc;
    logic [7:0] rx_next;
    coord_t     x_cand, y_cand;
    logic       csum_ok;

    assign rx_next = {rx_shift[6:0], sdi_s};
    assign x_cand  = {b0_q[B0_XHI_MSB:B0_XHI_LSB], b1_q[B1_XLO_MSB:B1_XLO_LSB]};
`ifdef SPI_DRAW_CHECKSUM_EN
    assign y_cand  = {b1_q[B1_YHI_MSB:B1_YHI_LSB], b2_q};
    assign csum_ok = (rx_next == (b0_q ^ b1_q ^ b2_q));
`else
    assign y_cand  = {b1_q[B1_YHI_MSB:B1_YHI_LSB], rx_next};
    assign csum_ok = 1'b1;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // next state; cs_n rising ends every byte state, clean or aborted
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (cs_n_fall) state_nx = ST_B0;
            ST_B0:     if (cs_n_rise) state_nx = ST_IDLE;
                       else if (byte_done) state_nx = ST_B1;
            ST_B1:     if (cs_n_rise) state_nx = ST_IDLE;
                       else if (byte_done) state_nx = ST_B2;
`ifdef SPI_DRAW_CHECKSUM_EN
            ST_B2:     if (cs_n_rise) state_nx = ST_IDLE;
                       else if (byte_done) state_nx = ST_B3;
            ST_B3:     if (cs_n_rise) state_nx = ST_IDLE;
                       else if (byte_done) state_nx = ST_COMMIT;
`else
            ST_B2:     if (cs_n_rise) state_nx = ST_IDLE;
                       else if (byte_done) state_nx = ST_COMMIT;
`endif
            ST_COMMIT: state_nx = cs_n_s ? ST_IDLE : ST_B0;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // output decode; the commit decision is taken on the last byte's final
    // rise so the registered outputs and ready appear together in ST_COMMIT
    always_comb begin
        in_pkt    = (state != ST_IDLE) && (state != ST_COMMIT);
        start     = (state == ST_IDLE) && cs_n_fall;
        abort     = in_pkt && cs_n_rise && !((state == ST_B0) && (bit_cnt == 3'd0));
        shift_en  = in_pkt && sck_rise && !cs_n_rise;
        byte_done = shift_en && (bit_cnt == 3'd7);
        pkt_done  = byte_done && (state == LAST_BYTE);
        pkt_ok    = pkt_done && (x_cand < H_LIM) && (y_cand < V_LIM) && csum_ok;
        err_inc   = abort || (pkt_done && !pkt_ok);
    end

    // datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
`ifdef SPI_DRAW_CHECKSUM_EN
            b2_q      <= 8'h00;
`endif
            skip_fall <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            brush_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 8'h00;
        end else begin
            if (start || cs_n_rise) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_next;
            end

            if (byte_done) begin
                case (state)
                    ST_B0:   b0_q <= rx_next;
                    ST_B1:   b1_q <= rx_next;
`ifdef SPI_DRAW_CHECKSUM_EN
                    ST_B2:   b2_q <= rx_next;
`endif
                    default: ;
                endcase
            end

            // An echoed byte is loaded after the master has sampled the
            // previous MSB; its own MSB must survive the next fall, so that
            // one fall is skipped.
            if (start) begin
                tx_shift  <= ECHO_SYNC;
                skip_fall <= 1'b0;
            end else if (byte_done) begin
                tx_shift  <= rx_next;
                skip_fall <= 1'b1;
            end else if (sck_fall && (state != ST_IDLE)) begin
                if (skip_fall) skip_fall <= 1'b0;
                else           tx_shift  <= {tx_shift[6:0], 1'b0};
            end

            ready_q <= pkt_ok;
            if (pkt_ok) begin
                x_q     <= x_cand;
                y_q     <= y_cand;
                color_q <= b0_q[B0_COLOR_MSB:B0_COLOR_LSB];
                brush_q <= b0_q[B0_BRUSH_BIT];
            end

            if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    assign bus.sdo       = tx_shift[7];
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.new_color = color_q;
    assign bus.brush     = brush_q;
    assign bus.ready     = ready_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_spi_draw_decoder.sv
module tb_spi_draw_decoder;
    import paint_pkg::*;

    localparam int HALF = 8;
`ifdef SPI_DRAW_CHECKSUM_EN
    localparam int PKT_BYTES = 4;
`else
    localparam int PKT_BYTES = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_draw_decoder_if bus();

    spi_draw_decoder #(.H_ACTIVE(640), .V_ACTIVE(480), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    int ready_cnt = 0;
    int last_ready_cyc = 0;
    int rise_cyc = 0;
    bit ready_prev = 1'b0;
    bit dbl_ready = 1'b0;

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            ready_cnt++;
            last_ready_cyc = cyc;
            if (ready_prev) dbl_ready = 1'b1;
        end
        ready_prev = (bus.ready === 1'b1);
    end

    // master: sdo sampled just before each rise, sdi changed after each fall
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.sdi = b[i];
            repeat (HALF) @(negedge clk);
            rd[i] = bus.sdo;
            bus.sck = 1'b1;
            rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic send_packet(input logic [7:0] b0, b1, b2,
                               output logic [7:0] e0, e1, e2);
        logic [7:0] d;
        spi_bits(b0, 8, e0);
        spi_bits(b1, 8, e1);
        spi_bits(b2, 8, e2);
`ifdef SPI_DRAW_CHECKSUM_EN
        spi_bits(b0 ^ b1 ^ b2, 8, d);
`endif
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
    endtask

    task automatic cs_high();
        bus.cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_out(input string name, input coord_t ex, input coord_t ey,
                             input color_t ec, input logic eb);
        checks++;
        if (bus.x !== ex || bus.y !== ey || bus.new_color !== ec || bus.brush !== eb) begin
            fails++;
            $display("FAIL %s: x/y/color/brush got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b",
                     name, bus.x, bus.y, bus.new_color, bus.brush, ex, ey, ec, eb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        check_out("reset_outputs", 10'd0, 10'd0, 3'd0, 1'b0);
        check_int("reset_ready", int'(bus.ready), 0);
        check_int("reset_err_cnt", int'(bus.err_cnt), 0);
        check_int("reset_sdo", int'(bus.sdo), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_valid();
        logic [7:0] e0, e1, e2;
        int r0 = ready_cnt;
        cs_low();
        send_packet(8'hD4, 8'h2C, 8'h5A, e0, e1, e2);
        cs_high();
        check_int("valid_ready_count", ready_cnt - r0, 1);
        check_int("valid_latency", last_ready_cyc - rise_cyc, 3);
        check_out("valid_fields", 10'd267, 10'd90, 3'b101, 1'b1);
        check_int("valid_err_cnt", int'(bus.err_cnt), 0);
    endtask

    task automatic test_out_of_range();
        logic [7:0] e0, e1, e2;
        int r0 = ready_cnt;
        cs_low();
        send_packet(8'hAA, 8'hF0, 8'h10, e0, e1, e2);
        cs_high();
        check_int("oor_no_ready", ready_cnt - r0, 0);
        check_out("oor_hold", 10'd267, 10'd90, 3'b101, 1'b1);
        check_int("oor_err_cnt", int'(bus.err_cnt), 1);
    endtask

    task automatic test_abort();
        logic [7:0] d, e0, e1, e2;
        int r0 = ready_cnt;
        cs_low();
        spi_bits(8'hD4, 8, d);
        spi_bits(8'h2C, 4, d);
        cs_high();
        check_int("abort_no_ready", ready_cnt - r0, 0);
        check_int("abort_err_cnt", int'(bus.err_cnt), 2);
        cs_low();
        send_packet(8'h21, 8'h48, 8'hC8, e0, e1, e2);
        cs_high();
        check_int("after_abort_ready", ready_cnt - r0, 1);
        check_out("after_abort_fields", 10'd82, 10'd200, 3'd2, 1'b0);
    endtask

    task automatic test_boundary();
        logic [7:0] e0, e1, e2;
        int r0 = ready_cnt;
        cs_low();
        send_packet(8'h89, 8'hFD, 8'hDF, e0, e1, e2);
        cs_high();
        check_int("edge_639_479_ready", ready_cnt - r0, 1);
        check_out("edge_639_479_fields", 10'd639, 10'd479, 3'd0, 1'b1);
        cs_low();
        send_packet(8'h0A, 8'h00, 8'h00, e0, e1, e2);
        cs_high();
        check_int("edge_x640_no_ready", ready_cnt - r0, 1);
        check_int("edge_x640_err", int'(bus.err_cnt), 3);
        cs_low();
        send_packet(8'h00, 8'h01, 8'hE0, e0, e1, e2);
        cs_high();
        check_int("edge_y480_no_ready", ready_cnt - r0, 1);
        check_int("edge_y480_err", int'(bus.err_cnt), 4);
        check_out("edge_hold", 10'd639, 10'd479, 3'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e0, e1, e2, f0, f1, f2;
        int r0 = ready_cnt;
        int t1;
        cs_low();
        send_packet(8'hD4, 8'h2C, 8'h5A, e0, e1, e2);
        t1 = last_ready_cyc;
        check_out("b2b_first_fields", 10'd267, 10'd90, 3'b101, 1'b1);
        send_packet(8'h21, 8'h48, 8'hC8, f0, f1, f2);
        cs_high();
        check_int("b2b_ready_count", ready_cnt - r0, 2);
        check_int("b2b_spacing", last_ready_cyc - t1, PKT_BYTES * 8 * 2 * HALF);
        check_out("b2b_second_fields", 10'd82, 10'd200, 3'd2, 1'b0);
        check_int("echo_b0", int'(e0), 'hA5);
        check_int("echo_b1", int'(e1), 'hD4);
        check_int("echo_b2", int'(e2), 'h2C);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, e0, e1, e2;
        int r0;
        cs_low();
        spi_bits(8'h89, 8, d);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_out("midreset_outputs", 10'd0, 10'd0, 3'd0, 1'b0);
        check_int("midreset_err", int'(bus.err_cnt), 0);
        check_int("midreset_sdo", int'(bus.sdo), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        r0 = ready_cnt;
        send_packet(8'hD4, 8'h2C, 8'h5A, e0, e1, e2);
        cs_high();
        check_int("midreset_no_fresh_fall", ready_cnt - r0, 0);
        cs_low();
        send_packet(8'h21, 8'h48, 8'hC8, e0, e1, e2);
        cs_high();
        check_int("midreset_then_ready", ready_cnt - r0, 1);
        check_out("midreset_then_fields", 10'd82, 10'd200, 3'd2, 1'b0);
        check_int("midreset_then_err", int'(bus.err_cnt), 0);
    endtask

`ifdef SPI_DRAW_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] d;
        int r0 = ready_cnt;
        int e0 = int'(bus.err_cnt);
        cs_low();
        spi_bits(8'hD4, 8, d); spi_bits(8'h2C, 8, d);
        spi_bits(8'h5A, 8, d); spi_bits(8'hA2, 8, d);
        cs_high();
        check_int("csum_good_ready", ready_cnt - r0, 1);
        check_out("csum_good_fields", 10'd267, 10'd90, 3'b101, 1'b1);
        cs_low();
        spi_bits(8'hD4, 8, d); spi_bits(8'h2C, 8, d);
        spi_bits(8'h5A, 8, d); spi_bits(8'hA3, 8, d);
        cs_high();
        check_int("csum_bad_no_ready", ready_cnt - r0, 1);
        check_int("csum_bad_err", int'(bus.err_cnt), e0 + 1);
    endtask
`endif

    task automatic test_err_saturate();
        logic [7:0] d;
        for (int i = 0; i < 300; i++) begin
            cs_low();
            spi_bits(8'h80, 1, d);
            cs_high();
        end
        check_int("err_saturate", int'(bus.err_cnt), 255);
    endtask

    initial begin
        bus.sck  = 1'b0;
        bus.sdi  = 1'b0;
        bus.cs_n = 1'b1;
        test_reset();
        test_valid();
        test_out_of_range();
        test_abort();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_DRAW_CHECKSUM_EN
        test_checksum();
`endif
        test_err_saturate();
        check_int("ready_never_double", int'(dbl_ready), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
